noc_local_flit_buffer: RTL and testbench

- Packet-aware flit FIFO between a local traffic source (test node sender or NI) and a router local input port.
- Absorbs back-pressure from the router, polices header/tail framing on ingress, and keeps packet counters for testbench checks.
- Uses the same flit/header/tail sideband convention as the router ports.

---
 rtl/noc_local_flit_buffer.sv | 167 ++++++++++++++++
 tb/tb_noc_local_flit_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_flit_buffer.sv
// Packet-aware flit FIFO from a local source into a router local input port.
// Optional store-and-forward release is enabled by defining NOC_BUF_STORE_FWD_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_flit_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`Noc_Data_Width-1:0] in_flit,
  input  logic                       in_is_header,
  input  logic                       in_is_tail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [`Noc_Data_Width-1:0] out_flit,
  output logic                       out_is_header,
  output logic                       out_is_tail,
  output logic [ADDR_W:0]            fill_level,
  output logic [CNT_W-1:0]           pkt_in_count,
  output logic [CNT_W-1:0]           pkt_out_count,
  output logic                       framing_error
);

  localparam int DW = `Noc_Data_Width;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

  state_t r_state;
  state_t w_state_next;

  // Entry layout: {flit, is_header, is_tail}
  logic [DW+1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_fill;
  logic [CNT_W-1:0]  r_pkt_in;
  logic [CNT_W-1:0]  r_pkt_out;
  logic              r_framing_error;

  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_tail_wr;
  logic          w_err_set;
  logic          w_tail_pop;
  logic [DW+1:0] w_head;

  assign w_empty  = (r_fill == '0);
  assign w_full   = (r_fill == FULL_LVL);
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_tail_pop = w_pop && w_head[0];

  assign out_flit      = w_empty ? '0   : w_head[DW+1:2];
  assign out_is_header = w_empty ? 1'b0 : w_head[1];
  assign out_is_tail   = w_empty ? 1'b0 : w_head[0];

  assign fill_level    = r_fill;
  assign pkt_in_count  = r_pkt_in;
  assign pkt_out_count = r_pkt_out;
  assign framing_error = r_framing_error;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:   if (in_is_header && !in_is_tail) w_state_next = ST_IN_PKT;
        ST_IN_PKT: if (in_is_tail)                  w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // A non-header flit outside a packet is consumed but never stored.
  always_comb begin
    w_wr_en   = 1'b0;
    w_tail_wr = 1'b0;
    w_err_set = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (in_is_header) begin
            w_wr_en   = 1'b1;
            w_tail_wr = in_is_tail;
          end else begin
            w_err_set = 1'b1;
          end
        end
        ST_IN_PKT: begin
          w_wr_en   = 1'b1;
          w_tail_wr = in_is_tail;
          w_err_set = in_is_header;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge noc_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {in_flit, in_is_header, in_is_tail};
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_fill          <= '0;
      r_pkt_in        <= '0;
      r_pkt_out       <= '0;
      r_framing_error <= 1'b0;
    end else begin
      if (w_wr_en)    r_wr_ptr  <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr  <= r_rd_ptr + 1'b1;
      if (w_tail_wr)  r_pkt_in  <= r_pkt_in + 1'b1;
      if (w_tail_pop) r_pkt_out <= r_pkt_out + 1'b1;
      if (w_err_set)  r_framing_error <= 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

`ifdef NOC_BUF_STORE_FWD_EN
  logic [ADDR_W:0] r_complete_cnt;
  logic            r_escape;

  // Escape latches when a flit leaves without a complete packet behind it,
  // so a packet longer than the buffer keeps draining until its tail goes.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_complete_cnt <= '0;
      r_escape       <= 1'b0;
    end else begin
      case ({w_tail_wr, w_tail_pop})
        2'b10:   r_complete_cnt <= r_complete_cnt + 1'b1;
        2'b01:   r_complete_cnt <= r_complete_cnt - 1'b1;
        default: r_complete_cnt <= r_complete_cnt;
      endcase
      if (w_tail_pop)                          r_escape <= 1'b0;
      else if (w_pop && r_complete_cnt == '0)  r_escape <= 1'b1;
    end
  end

  assign out_valid = !w_empty && ((r_complete_cnt != '0) || w_full || r_escape);
`else
  assign out_valid = !w_empty;
`endif

endmodule

// File: tb/tb_noc_local_flit_buffer.sv
// Directed self-checking bench for noc_local_flit_buffer (cut-through or store-and-forward).
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_local_flit_buffer;
  localparam int DW     = `Noc_Data_Width;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  logic              noc_clk = 1'b0;
  logic              noc_rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_flit;
  logic              in_is_header;
  logic              in_is_tail;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_flit;
  logic              out_is_header;
  logic              out_is_tail;
  logic [ADDR_W:0]   fill_level;
  logic [CNT_W-1:0]  pkt_in_count;
  logic [CNT_W-1:0]  pkt_out_count;
  logic              framing_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 noc_clk = ~noc_clk;

  noc_local_flit_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .fill_level(fill_level), .pkt_in_count(pkt_in_count),
    .pkt_out_count(pkt_out_count), .framing_error(framing_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] f, input logic h, input logic t);
    in_valid     = v;
    in_flit      = f;
    in_is_header = h;
    in_is_tail   = t;
  endtask

  initial begin
    logic [DW-1:0] ones;
    ones = '1;
    noc_rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_out_flit", 64'(out_flit), 64'(0));
    check_eq("rst_fill", 64'(fill_level), 64'(0));
    check_eq("rst_counts", 64'({pkt_in_count, pkt_out_count}), 64'(0));
    check_eq("rst_ferr", 64'(framing_error), 64'(0));
    noc_rst_n = 1'b1;
    tick();

`ifndef NOC_BUF_STORE_FWD_EN
    // 3-flit packet, each flit visible one cycle after its push
    out_ready = 1'b1;
    drive(1'b1, DW'('hA0), 1'b1, 1'b0); tick();
    check_eq("p3_h_valid", 64'(out_valid), 64'(1));
    check_eq("p3_h_flit", 64'(out_flit), 64'('hA0));
    check_eq("p3_h_hdr", 64'(out_is_header), 64'(1));
    drive(1'b1, ones, 1'b0, 1'b0); tick();
    check_eq("p3_d_flit", 64'(out_flit), 64'(ones));
    check_eq("p3_d_hdr", 64'(out_is_header), 64'(0));
    drive(1'b1, DW'('hC3), 1'b0, 1'b1); tick();
    check_eq("p3_t_flit", 64'(out_flit), 64'('hC3));
    check_eq("p3_t_tail", 64'(out_is_tail), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    check_eq("p3_fill", 64'(fill_level), 64'(0));
    check_eq("p3_valid", 64'(out_valid), 64'(0));
    check_eq("p3_pin", 64'(pkt_in_count), 64'(1));
    check_eq("p3_pout", 64'(pkt_out_count), 64'(1));
    check_eq("p3_ferr", 64'(framing_error), 64'(0));

    // Fill to DEPTH with the router stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'('h10 + i), (i == 0), (i == 7)); tick();
    end
    check_eq("full_in_ready", 64'(in_ready), 64'(0));
    check_eq("full_fill", 64'(fill_level), 64'(8));
    check_eq("full_pin", 64'(pkt_in_count), 64'(2));
    check_eq("full_head", 64'(out_flit), 64'('h10));
    drive(1'b1, DW'('h20), 1'b1, 1'b1);
    out_ready = 1'b1; tick();
    check_eq("fullpop_fill", 64'(fill_level), 64'(7));
    check_eq("fullpop_head", 64'(out_flit), 64'('h11));
    check_eq("fullpop_pin", 64'(pkt_in_count), 64'(2));
    out_ready = 1'b0; tick();
    check_eq("late_wr_fill", 64'(fill_level), 64'(8));
    check_eq("late_wr_pin", 64'(pkt_in_count), 64'(3));
    drive(1'b0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_valid", 64'(out_valid), 64'(1));
      check_eq("drain_flit", 64'(out_flit), (i < 7) ? 64'('h11 + i) : 64'('h20));
      tick();
    end
    check_eq("drain_fill", 64'(fill_level), 64'(0));
    check_eq("drain_pout", 64'(pkt_out_count), 64'(3));

    // Streaming push+pop across two pointer wraps
    drive(1'b1, DW'('h100), 1'b1, 1'b0); tick();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, DW'('h100 + k), 1'b0, (k == 20));
      check_eq("stream_flit", 64'(out_flit), 64'('h100 + k - 1));
      tick();
      check_eq("stream_fill", 64'(fill_level), 64'(1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check_eq("stream_last", 64'(out_flit), 64'('h114));
    tick();
    check_eq("stream_fill_end", 64'(fill_level), 64'(0));
    check_eq("stream_pin", 64'(pkt_in_count), 64'(4));
    check_eq("stream_pout", 64'(pkt_out_count), 64'(4));

    // Single-flit packet, then a stray body flit proves FSM is back in IDLE
    drive(1'b1, DW'('h88), 1'b1, 1'b1); tick();
    check_eq("single_flit", 64'(out_flit), 64'('h88));
    check_eq("single_flags", 64'({out_is_header, out_is_tail}), 64'(3));
    check_eq("single_pin", 64'(pkt_in_count), 64'(5));
    check_eq("single_ferr", 64'(framing_error), 64'(0));
    drive(1'b1, DW'('h55), 1'b0, 1'b0); tick();
    check_eq("stray_fill", 64'(fill_level), 64'(0));
    check_eq("stray_valid", 64'(out_valid), 64'(0));
    check_eq("stray_ferr", 64'(framing_error), 64'(1));
    check_eq("stray_pout", 64'(pkt_out_count), 64'(5));
    drive(1'b1, DW'('h66), 1'b1, 1'b0); tick();
    check_eq("after_err_h", 64'(out_flit), 64'('h66));
    drive(1'b1, DW'('h77), 1'b0, 1'b1); tick();
    check_eq("after_err_t", 64'(out_flit), 64'('h77));
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    check_eq("after_err_ferr", 64'(framing_error), 64'(1));
    check_eq("after_err_pin", 64'(pkt_in_count), 64'(6));
    check_eq("after_err_pout", 64'(pkt_out_count), 64'(6));

    // Asynchronous reset in the middle of a packet
    out_ready = 1'b0;
    drive(1'b1, DW'('h99), 1'b1, 1'b0); tick();
    drive(1'b1, DW'('hAA), 1'b0, 1'b0); tick();
    check_eq("mid_fill", 64'(fill_level), 64'(2));
    drive(1'b0, '0, 1'b0, 1'b0);
    noc_rst_n = 1'b0;
    #1;
    check_eq("arst_fill", 64'(fill_level), 64'(0));
    check_eq("arst_valid", 64'(out_valid), 64'(0));
    check_eq("arst_flit", 64'(out_flit), 64'(0));
    check_eq("arst_ferr", 64'(framing_error), 64'(0));
    check_eq("arst_in_ready", 64'(in_ready), 64'(1));
    tick();
    noc_rst_n = 1'b1;
    tick();
    drive(1'b1, DW'('hBB), 1'b1, 1'b1); tick();
    check_eq("post_rst_ferr", 64'(framing_error), 64'(0));
    check_eq("post_rst_pin", 64'(pkt_in_count), 64'(1));
    check_eq("post_rst_flit", 64'(out_flit), 64'('hBB));
    drive(1'b0, '0, 1'b0, 1'b0);
`else
    // Store-and-forward: header held back until the tail is written
    out_ready = 1'b1;
    drive(1'b1, DW'('h31), 1'b1, 1'b0); tick();
    check_eq("sf_h_hold", 64'(out_valid), 64'(0));
    drive(1'b1, DW'('h32), 1'b0, 1'b0); tick();
    check_eq("sf_d_hold", 64'(out_valid), 64'(0));
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      tick();
      check_eq("sf_gap_hold", 64'(out_valid), 64'(0));
    end
    drive(1'b1, DW'('h33), 1'b0, 1'b1); tick();
    check_eq("sf_release", 64'(out_valid), 64'(1));
    check_eq("sf_h_flit", 64'(out_flit), 64'('h31));
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    check_eq("sf_d_flit", 64'(out_flit), 64'('h32));
    tick();
    check_eq("sf_t_flit", 64'(out_flit), 64'('h33));
    tick();
    check_eq("sf_fill", 64'(fill_level), 64'(0));
    check_eq("sf_pout", 64'(pkt_out_count), 64'(1));

    // 10-flit packet forces the full escape
    begin
      int  sent;
      int  got;
      bit  released;
      bit  acc;
      sent = 0; got = 0; released = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
        if (sent < 10) drive(1'b1, DW'('h40 + sent), (sent == 0), (sent == 9));
        else           drive(1'b0, '0, 1'b0, 1'b0);
        if (out_valid) begin
          if (!released) begin
            check_eq("sf_esc_fill", 64'(fill_level), 64'(8));
            released = 1'b1;
          end
          check_eq("sf_esc_flit", 64'(out_flit), 64'('h40 + got));
          got++;
        end
        acc = in_valid && in_ready;
        tick();
        if (acc) sent++;
      end
      check_eq("sf_esc_count", 64'(got), 64'(10));
      drive(1'b0, '0, 1'b0, 1'b0);
      tick();
      check_eq("sf_esc_pout", 64'(pkt_out_count), 64'(2));
      check_eq("sf_esc_empty", 64'(fill_level), 64'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
